ioctl_upload_ctrl: RTL and testbench
====================================

// Module: ioctl_upload_ctrl
// PURPOSE
//  Read-back path for ROM/NVRAM upload from core to host: services data_io upload byte reads
//  by fetching 16-bit words from an SDRAM port over the toggle req/ack handshake.
//  Inverse of the download write path: ioctl_addr -> SDRAM word read -> byte on ioctl_din.
//  One-word cache so consecutive even/odd byte reads cost a single SDRAM access.
// PARAMETERS
//  AW       23      SDRAM word address width (port_a width)
//  BASE     0       word offset added to ioctl_addr[AW:1] before issue
//  TIMEOUT  1024    clk_sys cycles to wait for port_ack before aborting a fetch
// PORTS
//  clk_sys       in   1    system clock (SDRAM clock domain)
//  reset_n       in   1    asynchronous active-low reset
//  ioctl_upload  in   1    host upload session active (level)
//  ioctl_addr    in   25   byte address of requested byte, stable while ioctl_rd high
//  ioctl_rd      in   1    read request; rising edge = one request
//  ioctl_din     out  8    returned byte
//  din_valid     out  1    1-cycle pulse: ioctl_din holds byte for last request
//  busy          out  1    SDRAM fetch in flight or resync pending
//  err_timeout   out  1    sticky: a fetch timed out this session
//  err_overrun   out  1    sticky: a request arrived while busy (request dropped)
//  port_req      out  1    SDRAM request toggle
//  port_ack      in   1    SDRAM ack toggle; transfer complete when port_ack == port_req
//  port_a        out  AW   SDRAM word address
//  port_ds       out  2    byte enables, constant 2'b11
//  port_we       out  1    write enable, constant 0
//  port_q        in   16   SDRAM read data, valid when port_ack == port_req
// BEHAVIOUR
//  Reset: port_req=0, port_a=0, ioctl_din=8'h00, din_valid=0, busy=0, err_*=0,
//   cache_valid=0, state=IDLE. port_ds=2'b11 and port_we=0 at all times.
//  Request = rising edge of ioctl_rd (registered edge detect) while ioctl_upload=1; else ignored.
//  Byte select: ioctl_addr[0]=0 -> word[7:0], 1 -> word[15:8].
//  Word address: wa = ioctl_addr[AW:1] + BASE, truncated to AW bits (wraps, no saturation).
//  States:
//   IDLE: request with cache_valid && wa==cache_wa -> hit: ioctl_din=cached byte, din_valid
//         pulses on next cycle (latency 1 after edge-detect). Miss: port_a<=wa, port_req toggles,
//         busy<=1, timer<=0, latch byte-select -> WAIT.
//   WAIT: port_ack==port_req -> cache<=port_q, cache_wa<=port_a, cache_valid<=1, ioctl_din<=
//         selected byte, din_valid pulse, busy<=0 -> IDLE. Min miss latency = SDRAM ack + 1.
//         timer==TIMEOUT-1 without ack -> ioctl_din<=8'hFF, din_valid pulse, err_timeout<=1,
//         cache_valid<=0 -> RESYNC.
//   RESYNC: busy=1; wait for late port_ack==port_req (data discarded) -> IDLE. Guarantees no
//         stale ack is mistaken for the next request's completion.
//  Request while busy: dropped, err_overrun<=1, no din_valid.
//  ioctl_upload rising edge: cache_valid, err_timeout, err_overrun cleared.
//  ioctl_upload falling edge: cache_valid cleared; an in-flight fetch completes its handshake
//   but din_valid is suppressed; late ack in RESYNC still consumed.
//  Request and ack in same cycle in WAIT: ack processed, request counted as overrun.
//  din_valid never asserts outside ioctl_upload=1 except the single response to an accepted request.
// TESTING
//  Rd addr 0x000000, SDRAM model acks after 6 clks with q=16'hBEEF -> one port_req toggle,
//   port_a=0, din_valid with ioctl_din=8'hEF.
//  Follow with rd addr 0x000001 -> no port_req toggle, din_valid 1 cycle after edge, ioctl_din=8'hBE.
//  BASE=16'h7000, rd addr 0x000004 -> port_a=23'h7002; AW=16 with ioctl_addr[16:1]=16'hFFFF and BASE=1
//   -> port_a wraps to 0.
//  Model never acks, TIMEOUT=16 -> din_valid at cycle 16 with 8'hFF, err_timeout=1, busy held;
//   late ack at cycle 40 -> busy=0; next request completes correctly.
//  Second rd edge during WAIT -> err_overrun=1, exactly one din_valid; ioctl_upload re-rise clears flags.
//  Assert reset_n low mid-WAIT -> all outputs to reset values immediately, state IDLE, cache_valid=0.

Source files
------------

// File: rtl/ioctl_upload_ctrl_if.sv
// rtl/ioctl_upload_ctrl_if.sv - SDRAM read port bundle for the upload read-back path
interface ioctl_upload_ctrl_if #(
    parameter int AW = 23
);
    logic          port_req;
    logic          port_ack;
    logic [AW-1:0] port_a;
    logic [1:0]    port_ds;
    logic          port_we;
    logic [15:0]   port_q;

    modport master (
        output port_req, port_a, port_ds, port_we,
        input  port_ack, port_q
    );

    modport slave (
        input  port_req, port_a, port_ds, port_we,
        output port_ack, port_q
    );
endinterface

// File: rtl/ioctl_upload_ctrl.sv
// rtl/ioctl_upload_ctrl.sv - serves host upload byte reads from SDRAM words with a one-word cache
module ioctl_upload_ctrl #(
    parameter int AW      = 23,
    parameter int BASE    = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_upload,
    input  logic [24:0]          ioctl_addr,
    input  logic                 ioctl_rd,
    output logic [7:0]           ioctl_din,
    output logic                 din_valid,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun,
    ioctl_upload_ctrl_if.master  sd
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESYNC} state_t;

    state_t        state_q, state_d;
    logic          rd_q, up_q;
    logic          req_edge, up_rise, up_fall, ack_match;
    logic          hit, issue, done, tmo, resync_done;
    logic [AW-1:0] wa, cache_wa, port_a_q;
    logic [15:0]   cache;
    logic          cache_valid, port_req_q, sel_q;
    logic [TW-1:0] timer;
    logic          unused_addr;

    assign unused_addr = &{1'b0, ioctl_addr};

    assign sd.port_req = port_req_q;
    assign sd.port_a   = port_a_q;
    assign sd.port_ds  = 2'b11;
    assign sd.port_we  = 1'b0;

    assign req_edge  = ioctl_rd & ~rd_q & ioctl_upload;
    assign up_rise   = ioctl_upload & ~up_q;
    assign up_fall   = ~ioctl_upload & up_q;
    assign ack_match = (sd.port_ack == port_req_q);
    // Word address wraps modulo 2^AW by design.
    assign wa        = ioctl_addr[AW:1] + AW'(BASE);

    always_comb begin
        state_d     = state_q;
        hit         = 1'b0;
        issue       = 1'b0;
        done        = 1'b0;
        tmo         = 1'b0;
        resync_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_edge) begin
                    if (cache_valid && (wa == cache_wa)) begin
                        hit = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ack_match) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = S_RESYNC;
                end
            end
            S_RESYNC: begin
                // A late ack must be absorbed here so it cannot complete the next fetch.
                if (ack_match) begin
                    resync_done = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_q        <= 1'b0;
            up_q        <= 1'b0;
            ioctl_din   <= 8'h00;
            din_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            cache_valid <= 1'b0;
            cache       <= 16'h0000;
            cache_wa    <= '0;
            port_a_q    <= '0;
            port_req_q  <= 1'b0;
            sel_q       <= 1'b0;
            timer       <= '0;
        end else begin
            rd_q      <= ioctl_rd;
            up_q      <= ioctl_upload;
            din_valid <= 1'b0;
            if (up_rise || up_fall) begin
                cache_valid <= 1'b0;
            end
            if (up_rise) begin
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end
            if (req_edge && (state_q != S_IDLE)) begin
                err_overrun <= 1'b1;
            end
            if (hit) begin
                ioctl_din <= ioctl_addr[0] ? cache[15:8] : cache[7:0];
                din_valid <= 1'b1;
            end
            if (issue) begin
                port_a_q   <= wa;
                port_req_q <= ~port_req_q;
                busy       <= 1'b1;
                timer      <= '0;
                sel_q      <= ioctl_addr[0];
            end
            if ((state_q == S_WAIT) && !done && !tmo) begin
                timer <= timer + TW'(1);
            end
            // Upload ending mid-fetch: handshake still completes, response is swallowed.
            if (done) begin
                cache       <= sd.port_q;
                cache_wa    <= port_a_q;
                cache_valid <= ioctl_upload;
                ioctl_din   <= sel_q ? sd.port_q[15:8] : sd.port_q[7:0];
                din_valid   <= ioctl_upload;
                busy        <= 1'b0;
            end
            if (tmo) begin
                ioctl_din   <= 8'hFF;
                din_valid   <= ioctl_upload;
                err_timeout <= 1'b1;
                cache_valid <= 1'b0;
            end
            if (resync_done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ioctl_upload_ctrl.sv
// tb/tb_ioctl_upload_ctrl.sv - directed checks of the upload read-back controller
module tb_ioctl_upload_ctrl;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic        ioctl_rd = 1'b0;

    logic [7:0]  din0, din1, din2;
    logic        dv0, dv1, dv2, busy0, busy1, busy2;
    logic        et0, et1, et2, eo0, eo1, eo2;

    int          vectors = 0;
    int          fails = 0;
    int          tog = 0;
    logic        req_prev = 1'b0;
    logic        no_ack = 1'b0;
    logic [15:0] q_val = 16'h0000;
    int          cnt = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_ctrl_if #(.AW(23)) if0 ();
    ioctl_upload_ctrl_if #(.AW(23)) if1 ();
    ioctl_upload_ctrl_if #(.AW(16)) if2 ();

    ioctl_upload_ctrl #(.AW(23), .BASE(0), .TIMEOUT(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(din0),
        .din_valid(dv0), .busy(busy0), .err_timeout(et0), .err_overrun(eo0), .sd(if0)
    );
    ioctl_upload_ctrl #(.AW(23), .BASE(16'h7000), .TIMEOUT(16)) dut_base (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(din1),
        .din_valid(dv1), .busy(busy1), .err_timeout(et1), .err_overrun(eo1), .sd(if1)
    );
    ioctl_upload_ctrl #(.AW(16), .BASE(1), .TIMEOUT(16)) dut_wrap (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd), .ioctl_din(din2),
        .din_valid(dv2), .busy(busy2), .err_timeout(et2), .err_overrun(eo2), .sd(if2)
    );

    // SDRAM model for the main instance: acks 6 clocks after a new request.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            if0.port_ack <= 1'b0;
            cnt          <= 0;
        end else if (if0.port_req != if0.port_ack) begin
            if (!no_ack && cnt >= 5) begin
                if0.port_ack <= if0.port_req;
                if0.port_q   <= q_val;
                cnt          <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(posedge clk_sys) begin
        if1.port_ack <= if1.port_req;
        if1.port_q   <= 16'h0000;
        if2.port_ack <= if2.port_req;
        if2.port_q   <= 16'h0000;
    end

    always @(negedge clk_sys) begin
        if (if0.port_req != req_prev) tog++;
        req_prev = if0.port_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    // Raise ioctl_rd for one cycle; lat = negedges until din_valid seen, -1 if never.
    task automatic req(input logic [24:0] a, output int lat);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        lat        = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_sys);
            if (i == 1) ioctl_rd = 1'b0;
            if (dv0 && lat < 0) lat = i;
            if (lat > 0) break;
        end
    endtask

    initial begin
        int lat;
        int t0;
        int dvn;
        logic [7:0] last_din;

        tick(3);
        chk("rst_din", din0, 8'h00);
        chk("rst_dv", dv0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_errs", {et0, eo0}, 2'b00);
        chk("rst_req", if0.port_req, 1'b0);
        chk("rst_a", if0.port_a, 0);
        chk("port_ds", if0.port_ds, 2'b11);
        chk("port_we", if0.port_we, 1'b0);

        reset_n      = 1'b1;
        ioctl_upload = 1'b1;
        tick(3);

        q_val = 16'hBEEF;
        t0 = tog;
        req(25'h000000, lat);
        chk("miss0_lat", lat, 8);
        chk("miss0_din", din0, 8'hEF);
        chk("miss0_a", if0.port_a, 0);
        chk("miss0_tog", tog - t0, 1);
        chk("base_a0", if1.port_a, 23'h7000);

        tick(2);
        req(25'h000001, lat);
        chk("hit1_lat", lat, 1);
        chk("hit1_din", din0, 8'hBE);
        chk("hit1_tog", tog - t0, 1);

        tick(2);
        q_val = 16'hCAFE;
        req(25'h000004, lat);
        chk("miss4_din", din0, 8'hFE);
        chk("miss4_a", if0.port_a, 2);
        chk("base_a4", if1.port_a, 23'h7002);
        chk("miss4_tog", tog - t0, 2);

        tick(2);
        q_val = 16'h5A3C;
        req(25'h01FFFE, lat);
        chk("wrap_din", din0, 8'h3C);
        chk("wrap_a0", if0.port_a, 23'h00FFFF);
        chk("wrap_a", if2.port_a, 16'h0000);

        tick(2);
        no_ack = 1'b1;
        req(25'h000100, lat);
        chk("tmo_lat", lat, 17);
        chk("tmo_din", din0, 8'hFF);
        chk("tmo_err", et0, 1'b1);
        chk("tmo_busy", busy0, 1'b1);
        tick(20);
        chk("resync_busy", busy0, 1'b1);
        no_ack = 1'b0;
        tick(2);
        chk("late_ack_busy", busy0, 1'b0);

        tick(2);
        q_val = 16'hABCD;
        req(25'h000100, lat);
        chk("post_tmo_lat", lat, 8);
        chk("post_tmo_din", din0, 8'hCD);
        chk("post_tmo_err", et0, 1'b1);

        tick(2);
        q_val = 16'h1122;
        ioctl_addr = 25'h000200;
        ioctl_rd   = 1'b1;
        dvn        = 0;
        last_din   = 8'h00;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk_sys);
            if (dv0) begin
                dvn++;
                last_din = din0;
            end
            if (i == 1) ioctl_rd = 1'b0;
            if (i == 2) ioctl_rd = 1'b1;
            if (i == 3) ioctl_rd = 1'b0;
        end
        chk("ovr_dv_count", dvn, 1);
        chk("ovr_din", last_din, 8'h22);
        chk("ovr_err", eo0, 1'b1);

        ioctl_upload = 1'b0;
        tick(2);
        ioctl_upload = 1'b1;
        tick(2);
        chk("rerise_eo", eo0, 1'b0);
        chk("rerise_et", et0, 1'b0);

        q_val = 16'h7788;
        t0 = tog;
        req(25'h000201, lat);
        chk("rerise_miss_tog", tog - t0, 1);
        chk("rerise_din", din0, 8'h77);

        tick(2);
        no_ack = 1'b1;
        ioctl_addr = 25'h000300;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(3);
        chk("midwait_busy", busy0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy0, 1'b0);
        chk("arst_req", if0.port_req, 1'b0);
        chk("arst_a", if0.port_a, 0);
        chk("arst_din", din0, 8'h00);
        chk("arst_errs", {et0, eo0, dv0}, 3'b000);
        tick(2);
        no_ack  = 1'b0;
        reset_n = 1'b1;
        tick(4);

        q_val = 16'h99AA;
        t0 = tog;
        req(25'h000201, lat);
        chk("post_rst_tog", tog - t0, 1);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_din", din0, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
